sdram_arbit: RTL

Command-bus arbiter for the SDRAM controller: owns the single cmd/bank/addr/dq interface to the device and shares it between the init, auto-refresh, write and read engines.
- Hands the bus to `sdram_init` until `init_end`.
- Then grants one engine at a time by fixed priority: refresh > write > read.
- Each grant is held until that engine's `*_end` pulse.
- Sits between the engines (`sdram_init`, `sdram_aref`, `sdram_write`, `sdram_read`) and the device pins.

---
 rtl/sdram_pkg.sv | 26 ++
 rtl/sdram_arbit.sv | 122 ++++++++++++
 2 files changed

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM controller: device command encodings,
// arbiter state encodings and default bus widths.
package sdram_pkg;

  localparam int unsigned AddrW = 13;
  localparam int unsigned BankW = 2;
  localparam int unsigned DataW = 16;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CmdNop  = 4'b0111;
  localparam logic [3:0] CmdAct  = 4'b0011;
  localparam logic [3:0] CmdRd   = 4'b0101;
  localparam logic [3:0] CmdWr   = 4'b0100;
  localparam logic [3:0] CmdPre  = 4'b0010;
  localparam logic [3:0] CmdAref = 4'b0001;
  localparam logic [3:0] CmdMrs  = 4'b0000;

  typedef enum logic [2:0] {
    StIdle  = 3'b000,
    StArbit = 3'b001,
    StAref  = 3'b010,
    StWrite = 3'b011,
    StRead  = 3'b100
  } arb_state_e;

endpackage

// File: rtl/sdram_arbit.sv
// Command-bus arbiter: hands the SDRAM pins to init until it finishes, then to
// one of refresh/write/read at a time by fixed priority, held until *_end.
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrW,
  parameter int unsigned BANK_W = BankW,
  parameter int unsigned DATA_W = DataW
) (
  input  logic              arb_clk,
  input  logic              arb_rst_n,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [BANK_W-1:0] init_bank,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              aref_req,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [BANK_W-1:0] aref_bank,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_sdram_en,
  input  logic [DATA_W-1:0] wr_sdram_data,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [BANK_W-1:0] rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic [3:0]        sdram_cmd,
  output logic [BANK_W-1:0] sdram_bank,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic              sdram_dq_oe,
  output logic [DATA_W-1:0] sdram_dq_out
);

  arb_state_e r_state_q;
  arb_state_e w_state_d;
  logic       r_init_end_q;

  // init_end is registered once so the handover from init lands one edge later.
  always_ff @(posedge arb_clk or negedge arb_rst_n) begin
    if (!arb_rst_n) begin
      r_state_q    <= StIdle;
      r_init_end_q <= 1'b0;
    end else begin
      r_state_q    <= w_state_d;
      r_init_end_q <= init_end;
    end
  end

  always_comb begin
    w_state_d = r_state_q;
    case (r_state_q)
      StIdle: begin
        if (r_init_end_q) w_state_d = StArbit;
      end
      StArbit: begin
        if (aref_req)    w_state_d = StAref;
        else if (wr_req) w_state_d = StWrite;
        else if (rd_req) w_state_d = StRead;
      end
      StAref: begin
        if (aref_end) w_state_d = StArbit;
      end
      StWrite: begin
        if (wr_end) w_state_d = StArbit;
      end
      StRead: begin
        if (rd_end) w_state_d = StArbit;
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign aref_en = (r_state_q == StAref);
  assign wr_en   = (r_state_q == StWrite);
  assign rd_en   = (r_state_q == StRead);

  always_comb begin
    sdram_cmd  = init_cmd;
    sdram_bank = init_bank;
    sdram_addr = init_addr;
    case (r_state_q)
      StArbit: begin
        sdram_cmd  = CmdNop;
        sdram_bank = '1;
        sdram_addr = '1;
      end
      StAref: begin
        sdram_cmd  = aref_cmd;
        sdram_bank = aref_bank;
        sdram_addr = aref_addr;
      end
      StWrite: begin
        sdram_cmd  = wr_cmd;
        sdram_bank = wr_bank;
        sdram_addr = wr_addr;
      end
      StRead: begin
        sdram_cmd  = rd_cmd;
        sdram_bank = rd_bank;
        sdram_addr = rd_addr;
      end
      default: begin
        sdram_cmd  = init_cmd;
        sdram_bank = init_bank;
        sdram_addr = init_addr;
      end
    endcase
  end

  assign sdram_dq_oe  = (r_state_q == StWrite) & wr_sdram_en;
  assign sdram_dq_out = sdram_dq_oe ? wr_sdram_data : '0;

endmodule
